// File: rtl/music_score_player_if.sv
// Loader and playback signal bundle for music_score_player.
// master = loader/beat-timer side, slave = the player.
interface music_score_player_if #(
  parameter int DATA_WDTH = 5,
  parameter int COL_BITS  = 8
);
  logic                 W_EN;
  logic [COL_BITS-1:0]  addra;
  logic [DATA_WDTH-1:0] dina;
  logic                 start;
  logic                 stop;
  logic                 loop;
  logic [COL_BITS-1:0]  len;
  logic                 step;
  logic [DATA_WDTH-1:0] note;
  logic                 note_vld;
  logic [COL_BITS-1:0]  play_addr;
  logic                 busy;
  logic                 done;

  modport master (
    output W_EN, addra, dina,
    output start, stop, loop, len, step,
    input  note, note_vld, play_addr, busy, done
  );

  modport slave (
    input  W_EN, addra, dina,
    input  start, stop, loop, len, step,
    output note, note_vld, play_addr, busy, done
  );
endinterface

// File: rtl/music_score_player.sv
// Score RAM with independent write port and a playback sequencer.
// MUSIC_RAM_BYPASS_EN: write-first forwarding on read/write collision.
module music_score_player #(
  parameter int DATA_WDTH = 5,
  parameter int COL       = 100,
  parameter int COL_BITS  = 8
) (
  input logic clk,
  input logic rst,
  music_score_player_if.slave bus
);
  localparam int AW = $clog2(COL);
  localparam logic [COL_BITS:0] COL_W = (COL_BITS+1)'(COL);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t state, state_nxt;

  logic [DATA_WDTH-1:0] mem [COL];

  logic [COL_BITS-1:0]  play_addr, addr_nxt;
  logic [COL_BITS:0]    len_q, len_nxt;
  logic                 loop_q, loop_nxt;
  logic                 done_q, done_nxt;
  logic                 vld_q, vld_nxt;
  logic [DATA_WDTH-1:0] note_q;
  logic [DATA_WDTH-1:0] rd;
  logic [COL_BITS:0]    len_min;
  logic [COL_BITS:0]    last;
  logic                 wr_ok;

  assign wr_ok   = ({1'b0, bus.addra} < COL_W);
  assign len_min = ({1'b0, bus.len} > COL_W)
                 ? COL_W : {1'b0, bus.len};
  assign last    = len_q - 1'b1;

`ifdef MUSIC_RAM_BYPASS_EN
  assign rd = (bus.W_EN && wr_ok &&
               bus.addra == play_addr)
            ? bus.dina : mem[play_addr[AW-1:0]];
`else
  assign rd = mem[play_addr[AW-1:0]];
`endif

  // write port; contents survive reset
  always_ff @(posedge clk) begin
    if (bus.W_EN && wr_ok)
      mem[bus.addra[AW-1:0]] <= bus.dina;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state and sequencer control
  always_comb begin
    state_nxt = state;
    addr_nxt  = play_addr;
    len_nxt   = len_q;
    loop_nxt  = loop_q;
    done_nxt  = 1'b0;
    vld_nxt   = 1'b0;
    if (bus.stop) begin
      state_nxt = IDLE;
    end else if (bus.start && bus.len != '0) begin
      state_nxt = PLAY;
      addr_nxt  = '0;
      len_nxt   = len_min;
      loop_nxt  = bus.loop;
    end else if (state == PLAY) begin
      if (bus.step) begin
        if ({1'b0, play_addr} == last) begin
          if (loop_q) begin
            addr_nxt = '0;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          addr_nxt = play_addr + 1'b1;
        end
      end else begin
        vld_nxt = 1'b1;
      end
    end
  end

  // sequencer datapath and registered read
  always_ff @(posedge clk) begin
    if (rst) begin
      play_addr <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= 1'b0;
      note_q    <= '0;
    end else begin
      play_addr <= addr_nxt;
      len_q     <= len_nxt;
      loop_q    <= loop_nxt;
      done_q    <= done_nxt;
      vld_q     <= vld_nxt;
      if (state == PLAY) note_q <= rd;
    end
  end

  // outputs
  always_comb begin
    bus.busy      = (state == PLAY);
    bus.done      = done_q;
    bus.note_vld  = vld_q;
    bus.note      = note_q;
    bus.play_addr = play_addr;
  end
endmodule

// File: tb/tb_music_score_player.sv
// Directed bench for music_score_player.
// Build with +define+MUSIC_RAM_BYPASS_EN to check write-first.
module tb_music_score_player;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [4:0] model [100];

  always #5 clk = ~clk;

  music_score_player_if #(.DATA_WDTH(5), .COL_BITS(8)) bus();

  music_score_player #(
    .DATA_WDTH(5), .COL(100), .COL_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.W_EN = 0; bus.addra = 0; bus.dina = 0;
    bus.start = 0; bus.stop = 0; bus.loop = 0;
    bus.len = 0; bus.step = 0;
  endtask

  task automatic wr(input int a, input int d);
    bus.W_EN = 1; bus.addra = 8'(a); bus.dina = 5'(d);
    tick();
    bus.W_EN = 0;
    if (a < 100) model[a] = 5'(d);
  endtask

  task automatic go(input int l, input logic lp);
    bus.start = 1; bus.len = 8'(l); bus.loop = lp;
    tick();
    bus.start = 0;
  endtask

  task automatic halt();
    bus.stop = 1; tick(); bus.stop = 0; tick();
  endtask

  task automatic test_reset();
    rst = 1; tick(); rst = 0;
    n_chk += 5;
    if (bus.note !== 5'd0) begin n_fail++;
      $display("FAIL rst_note got %0d want 0", bus.note); end
    if (bus.note_vld !== 1'b0) begin n_fail++;
      $display("FAIL rst_vld got %b want 0", bus.note_vld); end
    if (bus.play_addr !== 8'd0) begin n_fail++;
      $display("FAIL rst_addr got %0d want 0", bus.play_addr); end
    if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL rst_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_fail++;
      $display("FAIL rst_done got %b want 0", bus.done); end
  endtask

  task automatic load();
    for (int i = 0; i < 100; i++) wr(i, (i * 3) % 32);
    wr(0, 5); wr(1, 6); wr(2, 7); wr(3, 8);
  endtask

  task automatic test_play_once();
    go(4, 0);
    n_chk += 2;
    if (bus.busy !== 1'b1) begin n_fail++;
      $display("FAIL once_busy_rise got %b want 1", bus.busy); end
    if (bus.note_vld !== 1'b0) begin n_fail++;
      $display("FAIL once_vld0 got %b want 0", bus.note_vld); end
    tick();
    for (int k = 0; k < 4; k++) begin
      n_chk += 3;
      if (bus.note !== 5'(k + 5)) begin n_fail++;
        $display("FAIL once_note%0d got %0d want %0d",
                 k, bus.note, k + 5); end
      if (bus.note_vld !== 1'b1) begin n_fail++;
        $display("FAIL once_vld%0d got %b want 1", k, bus.note_vld); end
      if (bus.done !== 1'b0) begin n_fail++;
        $display("FAIL once_nodone%0d got %b want 0", k, bus.done); end
      bus.step = 1; tick(); bus.step = 0;
      if (k < 3) begin
        n_chk++;
        if (bus.note_vld !== 1'b0) begin n_fail++;
          $display("FAIL once_vlddrop%0d got %b want 0",
                   k, bus.note_vld); end
        tick();
      end
    end
    n_chk += 3;
    if (bus.done !== 1'b1) begin n_fail++;
      $display("FAIL once_done got %b want 1", bus.done); end
    if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL once_busy_fall got %b want 0", bus.busy); end
    if (bus.play_addr !== 8'd3) begin n_fail++;
      $display("FAIL once_addr got %0d want 3", bus.play_addr); end
    tick();
    n_chk++;
    if (bus.done !== 1'b0) begin n_fail++;
      $display("FAIL once_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_loop();
    logic [4:0] exp_n [6];
    exp_n = '{5'd6, 5'd7, 5'd8, 5'd5, 5'd6, 5'd7};
    go(4, 1); tick();
    n_chk++;
    if (bus.note !== 5'd5) begin n_fail++;
      $display("FAIL loop_first got %0d want 5", bus.note); end
    for (int k = 0; k < 6; k++) begin
      bus.step = 1; tick(); bus.step = 0;
      n_chk += 3;
      if (bus.note_vld !== 1'b0) begin n_fail++;
        $display("FAIL loop_vlddrop%0d got %b want 0",
                 k, bus.note_vld); end
      if (bus.play_addr !== 8'((k + 1) % 4)) begin n_fail++;
        $display("FAIL loop_addr%0d got %0d want %0d",
                 k, bus.play_addr, (k + 1) % 4); end
      if (bus.done !== 1'b0) begin n_fail++;
        $display("FAIL loop_nodone%0d got %b want 0", k, bus.done); end
      tick();
      n_chk += 2;
      if (bus.note !== exp_n[k]) begin n_fail++;
        $display("FAIL loop_note%0d got %0d want %0d",
                 k, bus.note, exp_n[k]); end
      if (bus.busy !== 1'b1) begin n_fail++;
        $display("FAIL loop_busy%0d got %b want 1", k, bus.busy); end
    end
    bus.stop = 1; tick(); bus.stop = 0;
    n_chk += 2;
    if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL loop_stop_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_fail++;
      $display("FAIL loop_stop_done got %b want 0", bus.done); end
    tick();
  endtask

  task automatic test_len_zero();
    go(0, 0);
    for (int k = 0; k < 2; k++) begin
      n_chk += 2;
      if (bus.busy !== 1'b0) begin n_fail++;
        $display("FAIL len0_busy%0d got %b want 0", k, bus.busy); end
      if (bus.done !== 1'b0) begin n_fail++;
        $display("FAIL len0_done%0d got %b want 0", k, bus.done); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    go(200, 0);
    bus.step = 1;
    for (int k = 0; k < 99; k++) tick();
    bus.step = 0;
    n_chk += 3;
    if (bus.play_addr !== 8'd99) begin n_fail++;
      $display("FAIL clamp_addr got %0d want 99", bus.play_addr); end
    if (bus.note_vld !== 1'b0) begin n_fail++;
      $display("FAIL b2b_vld got %b want 0", bus.note_vld); end
    if (bus.busy !== 1'b1) begin n_fail++;
      $display("FAIL clamp_busy got %b want 1", bus.busy); end
    tick();
    n_chk += 2;
    if (bus.note !== model[99]) begin n_fail++;
      $display("FAIL clamp_note got %0d want %0d", bus.note, model[99]); end
    if (bus.note_vld !== 1'b1) begin n_fail++;
      $display("FAIL b2b_vld_back got %b want 1", bus.note_vld); end
    bus.step = 1; tick(); bus.step = 0;
    n_chk += 3;
    if (bus.done !== 1'b1) begin n_fail++;
      $display("FAIL clamp_done got %b want 1", bus.done); end
    if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL clamp_end_busy got %b want 0", bus.busy); end
    if (bus.play_addr !== 8'd99) begin n_fail++;
      $display("FAIL clamp_end_addr got %0d want 99", bus.play_addr); end
    tick();
  endtask

  task automatic test_stop_step();
    go(4, 0); tick();
    for (int k = 0; k < 2; k++) begin
      bus.step = 1; tick(); bus.step = 0; tick();
    end
    bus.stop = 1; bus.step = 1; tick();
    bus.stop = 0; bus.step = 0;
    n_chk += 4;
    if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL stop_busy got %b want 0", bus.busy); end
    if (bus.play_addr !== 8'd2) begin n_fail++;
      $display("FAIL stop_addr got %0d want 2", bus.play_addr); end
    if (bus.done !== 1'b0) begin n_fail++;
      $display("FAIL stop_done got %b want 0", bus.done); end
    if (bus.note_vld !== 1'b0) begin n_fail++;
      $display("FAIL stop_vld got %b want 0", bus.note_vld); end
    tick();
    n_chk++;
    if (bus.done !== 1'b0) begin n_fail++;
      $display("FAIL stop_done2 got %b want 0", bus.done); end
  endtask

  task automatic test_reset_mid();
    go(4, 0); tick();
    for (int k = 0; k < 2; k++) begin
      bus.step = 1; tick(); bus.step = 0; tick();
    end
    n_chk++;
    if (bus.play_addr !== 8'd2) begin n_fail++;
      $display("FAIL mid_pre_addr got %0d want 2", bus.play_addr); end
    test_reset();
  endtask

  task automatic test_rdw();
    logic [4:0] want;
`ifdef MUSIC_RAM_BYPASS_EN
    want = 5'd31;
`else
    want = 5'd5;
`endif
    go(4, 0); tick();
    wr(0, 31);
    n_chk++;
    if (bus.note !== want) begin n_fail++;
      $display("FAIL rdw_note got %0d want %0d", bus.note, want); end
    tick();
    n_chk++;
    if (bus.note !== 5'd31) begin n_fail++;
      $display("FAIL rdw_later got %0d want 31", bus.note); end
    halt();
  endtask

  task automatic test_drop();
    wr(120, 1);
    wr(200, 2);
    go(100, 0); tick();
    for (int i = 0; i < 100; i++) begin
      n_chk++;
      if (bus.note !== model[i] || bus.note_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL readback%0d got %0d/%b want %0d/1",
                 i, bus.note, bus.note_vld, model[i]);
      end
      bus.step = 1; tick(); bus.step = 0; tick();
    end
    n_chk++;
    if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL readback_end busy got %b want 0", bus.busy); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    load();
    test_play_once();
    test_loop();
    test_len_zero();
    test_back_to_back();
    test_stop_step();
    test_reset_mid();
    test_rdw();
    test_drop();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
